gpp_mc_core: RTL and testbench

Parametrised multi-cycle MIPS-subset general-purpose processor core. It is the successor to the fixed-width GPP and sits between the program ROM/RAM and the system controller. It adds:
- a Start/Done run handshake;
- a wait-stated memory fetch handshake;
- branches, halt, sign-extended immediates and a hardwired-zero r0;
- error reporting;
- a debug register read port for verification.

The register file is internal to the block.

---
 rtl/gpp_mc_core_if.sv | 14 +
 rtl/gpp_mc_core.sv | 167 ++++++++++++++++
 tb/tb_gpp_mc_core.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpp_mc_core_if.sv
// Instruction fetch bus between the core (master) and program memory (slave).
// En is held with a stable Addr until the memory answers with Ack and Data.
interface gpp_mc_core_if #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 8
);
  logic [SA_WIDTH-1:0] Addr;
  logic                En;
  logic                Ack;
  logic [D_WIDTH-1:0]  Data;

  modport master (output Addr, output En, input Ack, input Data);
  modport slave  (input Addr, input En, output Ack, output Data);
endinterface

// File: rtl/gpp_mc_core.sv
// Multi-cycle MIPS-subset core: 2 cycles per instruction (FETCH+EXEC) plus one per Ack-low cycle.
// Fetch stalls in FETCH with Addr/En held until Ack; Start is ignored unless IDLE.
module gpp_mc_core #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 8,
  parameter int PROG_LEN = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  gpp_mc_core_if.master      mem,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  input  logic [4:0]         Dbg_Addr,
  output logic [D_WIDTH-1:0] Dbg_Data
);
  // PC carries two extra bits so PROG_LEN = 2^SA_WIDTH and negative branch targets are representable.
  localparam int PW = SA_WIDTH + 2;
  localparam logic [PW-1:0] PLEN = PW'(PROG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t              state_q;
  logic [PW-1:0]       pc_q;
  logic [31:0]         ir_q;
  logic [SA_WIDTH-1:0] addr_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [D_WIDTH-1:0]  rf_q [32];

  logic [5:0]          op, fn;
  logic [4:0]          rs, rt, rd, sh;
  logic [D_WIDTH-1:0]  rs_v, rt_v, imm_sx;
  logic [PW-1:0]       tgt;
  logic                wb_en_d;
  logic [4:0]          wb_sel_d;
  logic [D_WIDTH-1:0]  wb_val_d;
  logic                err_d;
  logic                halt_d;
  logic                br_taken_d;
  logic                br_bad_d;
  logic [PW-1:0]       pc_d;

  always_comb begin
    op     = ir_q[31:26];
    rs     = ir_q[25:21];
    rt     = ir_q[20:16];
    rd     = ir_q[15:11];
    sh     = ir_q[10:6];
    fn     = ir_q[5:0];
    imm_sx = {{(D_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    rs_v   = rf_q[rs];
    rt_v   = rf_q[rt];

    wb_en_d    = 1'b0;
    wb_sel_d   = rd;
    wb_val_d   = '0;
    err_d      = 1'b0;
    halt_d     = 1'b0;
    br_taken_d = 1'b0;

    case (op)
      6'd0: begin
        wb_en_d = 1'b1;
        case (fn)
          6'd0:  wb_val_d = rt_v << sh;
          6'd2:  wb_val_d = rt_v >> sh;
          6'd24: wb_val_d = rs_v * rt_v;
          6'd26: begin
            if (rt_v == '0) begin
              wb_val_d = '1;
              err_d    = 1'b1;
            end else begin
              wb_val_d = rs_v / rt_v;
            end
          end
          6'd32: wb_val_d = rs_v + rt_v;
          6'd34: wb_val_d = rs_v - rt_v;
          default: begin
            wb_en_d = 1'b0;
            err_d   = 1'b1;
          end
        endcase
      end
      6'd8: begin
        wb_en_d  = 1'b1;
        wb_sel_d = rt;
        wb_val_d = rs_v + imm_sx;
      end
      6'd4:  br_taken_d = (rs_v == rt_v);
      6'd5:  br_taken_d = (rs_v != rt_v);
      6'd63: halt_d = 1'b1;
      default: err_d = 1'b1;
    endcase

    // pc_q already points past the branch, so this is PC+1+imm.
    tgt      = pc_q + imm_sx[PW-1:0];
    br_bad_d = br_taken_d && (tgt[PW-1] || ($signed(tgt) > $signed(PLEN)));
    pc_d     = br_taken_d ? tgt : pc_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            pc_q    <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem.Ack) begin
            ir_q    <= mem.Data[31:0];
            pc_q    <= pc_q + PW'(1);
            en_q    <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wb_en_d && (wb_sel_d != 5'd0)) rf_q[wb_sel_d] <= wb_val_d;
          if (err_d || br_bad_d) err_q <= 1'b1;
          pc_q <= pc_d;
          if (halt_d || br_bad_d || (pc_d == PLEN)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q  <= pc_d[SA_WIDTH-1:0];
            en_q    <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!Start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.Addr = addr_q;
  assign mem.En   = en_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign Dbg_Data = rf_q[Dbg_Addr];
endmodule

// File: tb/tb_gpp_mc_core.sv
// Directed bench: core A (PROG_LEN=3, wait-stated fetch) and core B (PROG_LEN=16, Ack tied high).
module tb_gpp_mc_core;
  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [4:0]  dbg_addr_a, dbg_addr_b;
  logic [31:0] dbg_data_a, dbg_data_b;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  int          waits_a, wcnt_a, max_b;
  logic [7:0]  hold_a;
  int          n_chk, n_fail;
  int          cyc;

  gpp_mc_core_if #(.D_WIDTH(32), .SA_WIDTH(8)) bus_a ();
  gpp_mc_core_if #(.D_WIDTH(32), .SA_WIDTH(8)) bus_b ();

  gpp_mc_core #(.D_WIDTH(32), .SA_WIDTH(8), .PROG_LEN(3)) u_a (
    .Clk(clk), .Rst(rst_n), .Start(start_a), .mem(bus_a.master),
    .Busy(busy_a), .Done(done_a), .Err(err_a),
    .Dbg_Addr(dbg_addr_a), .Dbg_Data(dbg_data_a)
  );

  gpp_mc_core #(.D_WIDTH(32), .SA_WIDTH(8), .PROG_LEN(16)) u_b (
    .Clk(clk), .Rst(rst_n), .Start(start_b), .mem(bus_b.master),
    .Busy(busy_b), .Done(done_b), .Err(err_b),
    .Dbg_Addr(dbg_addr_b), .Dbg_Data(dbg_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory A: Ack after waits_a stalled cycles; Addr must not move while stalled.
  assign bus_a.Data = rom_a[bus_a.Addr];
  initial bus_a.Ack = 1'b0;
  always @(negedge clk) begin
    if (bus_a.En !== 1'b1) begin
      wcnt_a    = 0;
      bus_a.Ack = 1'b0;
    end else begin
      if (wcnt_a == 0) hold_a = bus_a.Addr;
      else chk("addr_hold", 32'(bus_a.Addr), 32'(hold_a));
      bus_a.Ack = (wcnt_a >= waits_a);
      wcnt_a++;
    end
  end

  // Memory B: Ack permanently high, so Ack with En low is also exercised.
  assign bus_b.Data = rom_b[bus_b.Addr];
  assign bus_b.Ack  = 1'b1;
  always @(negedge clk) begin
    if (bus_b.En === 1'b1 && int'(bus_b.Addr) > max_b) max_b = int'(bus_b.Addr);
  end

  task automatic chk_reg(input bit b, input string tag, input logic [4:0] idx, input logic [31:0] exp);
    if (b) dbg_addr_b = idx; else dbg_addr_a = idx;
    #1;
    chk(tag, b ? dbg_data_b : dbg_data_a, exp);
  endtask

  // Assert Start just after an edge and hold it through the run; count edges until Done.
  task automatic run(input bit b, output int n);
    bit fin;
    logic d, bz;
    n   = 0;
    fin = 1'b0;
    max_b = -1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    while (!fin) begin
      @(posedge clk);
      #1;
      n++;
      d  = b ? done_b : done_a;
      bz = b ? busy_b : busy_a;
      chk("busy_done_excl", 32'(d & bz), 32'd0);
      if (n == 1) chk("busy_after_start", 32'(bz), 32'd1);
      if (d) fin = 1'b1;
      else if (n > 300) begin
        chk("run_timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("done_held_while_start", 32'(b ? done_b : done_a), 32'd1);
    if (b) start_b = 1'b0; else start_a = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clear", 32'(b ? done_b : done_a), 32'd0);
  endtask

  task automatic clear_b();
    for (int i = 0; i < 256; i++) rom_b[i] = 32'h0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    waits_a = 0; wcnt_a = 0; max_b = -1;
    start_a = 1'b0; start_b = 1'b0;
    dbg_addr_a = 5'd0; dbg_addr_b = 5'd0;
    for (int i = 0; i < 256; i++) rom_a[i] = 32'h0;
    clear_b();
    rom_a[0] = 32'h20010005;
    rom_a[1] = 32'h2002FFFD;
    rom_a[2] = 32'h00221820;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err",  32'(err_a), 32'd0);
    chk("rst_en",   32'(bus_a.En), 32'd0);
    chk("rst_addr", 32'(bus_a.Addr), 32'd0);
    chk_reg(0, "rst_r5", 5'd5, 32'h0);

    // Add run, no wait states.
    run(0, cyc);
    chk("add_cycles", 32'(cyc), 32'd7);
    chk("add_err", 32'(err_a), 32'd0);
    chk_reg(0, "add_r1", 5'd1, 32'h00000005);
    chk_reg(0, "add_r2", 5'd2, 32'hFFFFFFFD);
    chk_reg(0, "add_r3", 5'd3, 32'h00000002);

    // Same program with three stalled cycles per fetch, from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waits_a = 3;
    run(0, cyc);
    chk("wait_cycles", 32'(cyc), 32'd16);
    chk_reg(0, "wait_r1", 5'd1, 32'h00000005);
    chk_reg(0, "wait_r2", 5'd2, 32'hFFFFFFFD);
    chk_reg(0, "wait_r3", 5'd3, 32'h00000002);

    // Reset while the first fetch is stalled.
    start_a = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midrun_en_before", 32'(bus_a.En), 32'd1);
    chk("midrun_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    start_a = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrun_en", 32'(bus_a.En), 32'd0);
    chk("midrun_busy", 32'(busy_a), 32'd0);
    chk_reg(0, "midrun_r1", 5'd1, 32'h0);
    chk_reg(0, "midrun_r2", 5'd2, 32'h0);
    chk_reg(0, "midrun_r3", 5'd3, 32'h0);
    waits_a = 0;
    run(0, cyc);
    chk("restart_cycles", 32'(cyc), 32'd7);
    chk_reg(0, "restart_r3", 5'd3, 32'h00000002);

    // ALU mix on core B, ending on a branch whose target is exactly PROG_LEN.
    clear_b();
    rom_b[0] = 32'h20000009;
    rom_b[1] = 32'h20010006;
    rom_b[2] = 32'h2002FFF9;
    rom_b[3] = 32'h00221818;
    rom_b[4] = 32'h00222022;
    rom_b[5] = 32'h00022900;
    rom_b[6] = 32'h00023702;
    rom_b[7] = 32'h0041381A;
    rom_b[8] = 32'h10000007;
    rom_b[9] = 32'h20080001;
    run(1, cyc);
    chk("alu_cycles", 32'(cyc), 32'd19);
    chk("alu_err", 32'(err_b), 32'd0);
    chk_reg(1, "alu_r0", 5'd0, 32'h00000000);
    chk_reg(1, "alu_r3_mul", 5'd3, 32'hFFFFFFD6);
    chk_reg(1, "alu_r4_sub", 5'd4, 32'h0000000D);
    chk_reg(1, "alu_r5_sll", 5'd5, 32'hFFFFFF90);
    chk_reg(1, "alu_r6_srl", 5'd6, 32'h0000000F);
    chk_reg(1, "alu_r7_divu", 5'd7, 32'h2AAAAAA9);
    chk_reg(1, "alu_r8_skipped", 5'd8, 32'h00000000);

    // Divide by zero keeps running.
    clear_b();
    rom_b[0] = 32'h20010007;
    rom_b[1] = 32'h20020000;
    rom_b[2] = 32'h0022181A;
    rom_b[3] = 32'h20040001;
    rom_b[4] = 32'hFC000000;
    run(1, cyc);
    chk("div0_err", 32'(err_b), 32'd1);
    chk_reg(1, "div0_r3", 5'd3, 32'hFFFFFFFF);
    chk_reg(1, "div0_r4", 5'd4, 32'h00000001);

    // Countdown loop then halt; Err from the previous run must be cleared.
    clear_b();
    rom_b[0] = 32'h20010003;
    rom_b[1] = 32'h2021FFFF;
    rom_b[2] = 32'h1420FFFE;
    rom_b[3] = 32'hFC000000;
    run(1, cyc);
    chk("loop_cycles", 32'(cyc), 32'd17);
    chk("loop_err", 32'(err_b), 32'd0);
    chk("loop_max_fetch", 32'(max_b), 32'd3);
    chk_reg(1, "loop_r1", 5'd1, 32'h00000000);

    // Backward branch before address 0.
    clear_b();
    rom_b[0] = 32'h1000FFFB;
    rom_b[1] = 32'h20090001;
    run(1, cyc);
    chk("bro_cycles", 32'(cyc), 32'd3);
    chk("bro_err", 32'(err_b), 32'd1);
    chk("bro_max_fetch", 32'(max_b), 32'd0);
    chk_reg(1, "bro_r9", 5'd9, 32'h00000000);

    // Unknown opcode 0x3C: no write, error, execution continues.
    clear_b();
    rom_b[0] = 32'h20010005;
    rom_b[1] = 32'hF0010007;
    rom_b[2] = 32'h20090002;
    rom_b[3] = 32'hFC000000;
    run(1, cyc);
    chk("unk_cycles", 32'(cyc), 32'd9);
    chk("unk_err", 32'(err_b), 32'd1);
    chk_reg(1, "unk_r1", 5'd1, 32'h00000005);
    chk_reg(1, "unk_r9", 5'd9, 32'h00000002);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
